// File: rtl/fa_chk_pkg.sv
// rtl/fa_chk_pkg.sv - state type, vector count and golden full-adder functions for fa_exhaustive_checker
package fa_chk_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    SETTLE,
    CHECK,
    DONE
  } state_t;

  localparam int NUM_VECTORS = 8;

  function automatic logic exp_sum(input logic a, input logic b, input logic c);
    return a ^ b ^ c;
  endfunction

  function automatic logic exp_cout(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/fa_golden_model.sv
// rtl/fa_golden_model.sv - combinational reference full adder used by the checker's compare stage
module fa_golden_model
  import fa_chk_pkg::*;
(
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_s,
  output logic o_cout
);

  assign o_s    = exp_sum(i_a, i_b, i_cin);
  assign o_cout = exp_cout(i_a, i_b, i_cin);

endmodule

// File: rtl/fa_exhaustive_checker.sv
// rtl/fa_exhaustive_checker.sv - sweeps all 8 full-adder vectors, compares DUT outputs, counts mismatches (optional FA_CHK_STOP_ON_FAIL_EN)
module fa_exhaustive_checker
  import fa_chk_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int ERR_W         = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             A_o,
  output logic             B_o,
  output logic             Cin_o,
  input  logic             S_i,
  input  logic             Cout_i,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             fail_valid,
  output logic [2:0]       fail_vec
);

  // Last settle-count value; unused when SETTLE is skipped entirely.
  localparam logic [3:0]       SETTLE_LAST = (SETTLE_CYCLES > 0) ? 4'(SETTLE_CYCLES - 1) : 4'd0;
  localparam logic [ERR_W-1:0] ERR_MAX     = '1;
  localparam logic [2:0]       LAST_VEC    = 3'(NUM_VECTORS - 1);

  state_t           r_state;
  state_t           w_next;
  logic [2:0]       r_v;
  logic [2:0]       r_stim;
  logic [3:0]       r_settle_cnt;
  logic [ERR_W-1:0] r_err_count;
  logic             r_fail_valid;
  logic [2:0]       r_fail_vec;

  logic             w_exp_s;
  logic             w_exp_cout;
  logic             w_mismatch;
  logic             w_last_vec;
  logic             w_settled;

  // Expected values come from the registered stimulus the DUT actually sees.
  fa_golden_model u_golden (
    .i_a    (r_stim[2]),
    .i_b    (r_stim[1]),
    .i_cin  (r_stim[0]),
    .o_s    (w_exp_s),
    .o_cout (w_exp_cout)
  );

  assign w_mismatch = (S_i != w_exp_s) || (Cout_i != w_exp_cout);
  assign w_last_vec = (r_v == LAST_VEC);
  assign w_settled  = (r_settle_cnt == SETTLE_LAST);

  assign A_o        = r_stim[2];
  assign B_o        = r_stim[1];
  assign Cin_o      = r_stim[0];
  assign err_count  = r_err_count;
  assign fail_valid = r_fail_valid;
  assign fail_vec   = r_fail_vec;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state: start only matters when no run is in flight.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (start) w_next = DRIVE;
      end
      DRIVE: begin
        w_next = (SETTLE_CYCLES > 0) ? SETTLE : CHECK;
      end
      SETTLE: begin
        if (w_settled) w_next = CHECK;
      end
      CHECK: begin
`ifdef FA_CHK_STOP_ON_FAIL_EN
        w_next = (w_mismatch || w_last_vec) ? DONE : DRIVE;
`else
        w_next = w_last_vec ? DONE : DRIVE;
`endif
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Status outputs decoded from the current state.
  always_comb begin
    busy = (r_state == DRIVE) || (r_state == SETTLE) || (r_state == CHECK);
    done = (r_state == DONE);
    pass = (r_state == DONE) && (r_err_count == '0);
  end

  // Vector index, stimulus, settle timer and mismatch capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v          <= 3'd0;
      r_stim       <= 3'd0;
      r_settle_cnt <= 4'd0;
      r_err_count  <= '0;
      r_fail_valid <= 1'b0;
      r_fail_vec   <= 3'd0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_v          <= 3'd0;
            r_err_count  <= '0;
            r_fail_valid <= 1'b0;
            r_fail_vec   <= 3'd0;
          end
        end
        DRIVE: begin
          r_stim       <= r_v;
          r_settle_cnt <= 4'd0;
        end
        SETTLE: begin
          r_settle_cnt <= r_settle_cnt + 4'd1;
        end
        CHECK: begin
          if (w_mismatch) begin
            if (r_err_count != ERR_MAX) r_err_count <= r_err_count + ERR_W'(1);
            if (!r_fail_valid) begin
              r_fail_valid <= 1'b1;
              r_fail_vec   <= r_stim;
            end
          end
          if (!w_last_vec) r_v <= r_v + 3'd1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fa_exhaustive_checker.sv
// tb/tb_fa_exhaustive_checker.sv - self-checking bench for fa_exhaustive_checker with run-timeline model and directed scenarios
module tb_fa_exhaustive_checker;

`ifdef FA_CHK_STOP_ON_FAIL_EN
  localparam bit STOP    = 1'b1;
  localparam int T2_LAT  = 6;
  localparam int T2_ERR  = 1;
  localparam int T2_STIM = 1;
  localparam int T3_LAT  = 2;
  localparam int T3_ERR  = 1;
`else
  localparam bit STOP    = 1'b0;
  localparam int T2_LAT  = 24;
  localparam int T2_ERR  = 4;
  localparam int T2_STIM = 7;
  localparam int T3_LAT  = 16;
  localparam int T3_ERR  = 3;
`endif

  localparam int P_A = 3;  // 2 + SETTLE_CYCLES(1)
  localparam int P_B = 2;  // 2 + SETTLE_CYCLES(0)

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic start_a, start_b;
  int   fm_a, fm_b;  // 0 correct adder, 1 S stuck-at-0, 2 Cout inverted
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic       a_A, a_B, a_Cin, a_S, a_Cout, a_busy, a_done, a_pass, a_fv;
  logic [2:0] a_fvec;
  logic [3:0] a_err;
  logic [1:0] a_sum;
  logic       b_A, b_B, b_Cin, b_S, b_Cout, b_busy, b_done, b_pass, b_fv;
  logic [2:0] b_fvec;
  logic [1:0] b_err;
  logic [1:0] b_sum;

  // Full adders under test, with selectable faults.
  assign a_sum  = {1'b0, a_A} + {1'b0, a_B} + {1'b0, a_Cin};
  assign a_S    = (fm_a == 1) ? 1'b0 : a_sum[0];
  assign a_Cout = a_sum[1] ^ (fm_a == 2);
  assign b_sum  = {1'b0, b_A} + {1'b0, b_B} + {1'b0, b_Cin};
  assign b_S    = (fm_b == 1) ? 1'b0 : b_sum[0];
  assign b_Cout = b_sum[1] ^ (fm_b == 2);

  fa_exhaustive_checker #(.SETTLE_CYCLES(1), .ERR_W(4)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a),
    .A_o(a_A), .B_o(a_B), .Cin_o(a_Cin), .S_i(a_S), .Cout_i(a_Cout),
    .busy(a_busy), .done(a_done), .pass(a_pass), .err_count(a_err),
    .fail_valid(a_fv), .fail_vec(a_fvec)
  );

  fa_exhaustive_checker #(.SETTLE_CYCLES(0), .ERR_W(2)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b),
    .A_o(b_A), .B_o(b_B), .Cin_o(b_Cin), .S_i(b_S), .Cout_i(b_Cout),
    .busy(b_busy), .done(b_done), .pass(b_pass), .err_count(b_err),
    .fail_valid(b_fv), .fail_vec(b_fvec)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Model: a run is a timeline of 8 slots of P cycles; vector i is driven at
  // offset i*P+1 and judged at offset (i+1)*P after the accepting edge.
  bit m_busy[2], m_done[2], m_fv[2];
  int m_t[2], m_err[2], m_stim[2], m_fvec[2];

  function automatic bit vec_bad(input int i, input int fm);
    int ones;
    ones = ((i >> 2) & 1) + ((i >> 1) & 1) + (i & 1);
    case (fm)
      1:       return (ones % 2) == 1;
      2:       return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_step(input int n, input int p, input int emax, input bit st, input int fm);
    int i;
    if (!m_busy[n] && st) begin
      m_busy[n] = 1'b1; m_done[n] = 1'b0; m_t[n] = 0;
      m_err[n] = 0; m_fv[n] = 1'b0; m_fvec[n] = 0;
    end else if (m_busy[n]) begin
      m_t[n]++;
      if ((m_t[n] - 1) % p == 0) m_stim[n] = (m_t[n] - 1) / p;
      if (m_t[n] % p == 0) begin
        i = m_t[n] / p - 1;
        if (vec_bad(i, fm)) begin
          if (m_err[n] < emax) m_err[n]++;
          if (!m_fv[n]) begin m_fv[n] = 1'b1; m_fvec[n] = i; end
          if (STOP) begin m_busy[n] = 1'b0; m_done[n] = 1'b1; end
        end
        if (i == 7) begin m_busy[n] = 1'b0; m_done[n] = 1'b1; end
      end
    end
  endtask

  function automatic logic [13:0] exp_vec(input int n);
    return {3'(m_stim[n]), m_busy[n], m_done[n], m_done[n] && (m_err[n] == 0),
            m_fv[n], 3'(m_fvec[n]), 4'(m_err[n])};
  endfunction

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        for (int n = 0; n < 2; n++) begin
          m_busy[n] = 1'b0; m_done[n] = 1'b0; m_fv[n] = 1'b0;
          m_t[n] = 0; m_err[n] = 0; m_stim[n] = 0; m_fvec[n] = 0;
        end
      end else begin
        model_step(0, P_A, 15, start_a, fm_a);
        model_step(1, P_B, 3, start_b, fm_b);
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  initial begin
    forever begin
      @(negedge clk);
      chk("model_a", {a_A, a_B, a_Cin, a_busy, a_done, a_pass, a_fv, a_fvec, a_err}, exp_vec(0));
      chk("model_b", {b_A, b_B, b_Cin, b_busy, b_done, b_pass, b_fv, b_fvec, 2'b00, b_err}, exp_vec(1));
    end
  end

  task automatic pulse_start(input int which, output int k);
    @(posedge clk); #2;
    if (which == 0) start_a = 1'b1; else start_b = 1'b1;
    @(posedge clk); #1;
    k = cyc;
    #1;
    if (which == 0) start_a = 1'b0; else start_b = 1'b0;
  endtask

  task automatic wait_done(input int which, input int k, output int lat);
    for (int n = 0; n < 200; n++) begin
      if ((which == 0) ? a_done : b_done) break;
      @(posedge clk); #1;
    end
    lat = cyc - k;
  endtask

  initial begin
    int         k, lat;
    logic [2:0] seen[$];
    logic [2:0] s;
    logic [23:0] acc;
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; fm_a = 0; fm_b = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_a", {a_A, a_B, a_Cin, a_busy, a_done, a_pass, a_fv, a_fvec, a_err}, 0);
    chk("reset_b", {b_A, b_B, b_Cin, b_busy, b_done, b_pass, b_fv, b_fvec, b_err}, 0);
    #1 rst = 1'b0;

    // Correct adder: 24-cycle latency, pass, ordered sweep.
    pulse_start(0, k);
    seen = {};
    for (int n = 0; n < 200 && !a_done; n++) begin
      s = {a_A, a_B, a_Cin};
      if (a_busy && (seen.size() == 0 || seen[$] != s)) seen.push_back(s);
      @(posedge clk); #1;
    end
    lat = cyc - k;
    chk("t1_done", a_done, 1);
    chk("t1_latency", lat, 24);
    chk("t1_result", {a_pass, a_fv, a_err}, {1'b1, 1'b0, 4'd0});
    acc = '0;
    for (int i = 0; i < 8; i++) if (i < seen.size()) acc[i*3 +: 3] = seen[i];
    chk("t1_sweep_len", seen.size(), 8);
    chk("t1_sweep", acc, 24'o76543210);

    // S stuck-at-0: mismatches at 1,2,4,7.
    fm_a = 1;
    pulse_start(0, k);
    wait_done(0, k, lat);
    chk("t2_latency", lat, T2_LAT);
    chk("t2_err", a_err, T2_ERR);
    chk("t2_fail", {a_fv, a_fvec, a_pass}, {1'b1, 3'b001, 1'b0});
    chk("t2_stim", {a_A, a_B, a_Cin}, T2_STIM);

    // Asynchronous reset mid-run at v=3 in SETTLE.
    fm_a = 0;
    pulse_start(0, k);
    repeat (10) @(posedge clk);
    #3;
    chk("t4_pre_rst", {a_A, a_B, a_Cin, a_busy}, {3'd3, 1'b1});
    rst = 1'b1;
    #1;
    chk("t4_rst_async", {a_A, a_B, a_Cin, a_busy, a_done, a_pass, a_fv, a_fvec, a_err}, 0);
    #3 rst = 1'b0;
    pulse_start(0, k);
    wait_done(0, k, lat);
    chk("t4_latency", lat, 24);
    chk("t4_pass", {a_pass, a_err}, {1'b1, 4'd0});

    // Cout inverted with 2-bit counter: saturates at 3.
    fm_b = 2;
    pulse_start(1, k);
    wait_done(1, k, lat);
    chk("t3_latency", lat, T3_LAT);
    chk("t3_err", b_err, T3_ERR);
    chk("t3_fail", {b_fv, b_fvec, b_pass}, {1'b1, 3'b000, 1'b0});

    // start held high 30 cycles, SETTLE_CYCLES=0.
    fm_b = 0;
    @(posedge clk); #2 start_b = 1'b1;
    @(posedge clk); #1;
    k = cyc;
    chk("t5_clear", {b_busy, b_done, b_fv, b_err}, {1'b1, 1'b0, 1'b0, 2'b00});
    wait_done(1, k, lat);
    chk("t5_latency", lat, 16);
    @(posedge clk); #1;
    chk("t5_restart", {b_busy, b_done}, 2'b10);
    repeat (12) @(posedge clk);
    #2 start_b = 1'b0;
    @(posedge clk); #2 start_b = 1'b1;
    @(posedge clk); #2 start_b = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("t5_no_restart", {b_busy, b_done, b_pass}, 3'b011);

    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
